// File: rtl/seg7_pkg.sv
// Shared types, widths and helpers for the seven-segment scan controller.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam int CODE_W = 3;
    localparam int SEG_W  = 7;

    // One bit of a one-hot digit enable: set when the scanned index hits this position.
    function automatic logic onehot_bit(input int idx, input int pos);
        return idx == pos;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Frame-load handshake between a frame producer and the scan controller.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                                    load_valid;
    logic [seg7_pkg::CODE_W*NUM_DIGITS-1:0] load_data;
    logic                                    load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/seg7_frame_buf.sv
// Pending/display double buffer: loads land in pending, a commit moves them to display.
module seg7_frame_buf
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_valid,
    input  logic [CODE_W*NUM_DIGITS-1:0] load_data,
    output logic                         load_ready,
    input  logic                         commit,
    output logic [CODE_W*NUM_DIGITS-1:0] display,
    output logic [CODE_W-1:0]            next_first
);
    localparam int FB_W = CODE_W * NUM_DIGITS;

    logic [FB_W-1:0] pending_reg, pending_next;
    logic [FB_W-1:0] display_reg, display_next;
    logic            pending_full_reg, pending_full_next;
    logic            accept;
    logic            do_commit;

    assign accept    = load_valid & ~pending_full_reg;
    assign do_commit = commit & pending_full_reg;

    always_comb begin
        pending_next      = pending_reg;
        pending_full_next = pending_full_reg;
        display_next      = display_reg;
        if (do_commit) begin
            display_next      = pending_reg;
            pending_full_next = 1'b0;
        end
        // accept only happens while pending is empty, so it never collides with a commit
        if (accept) begin
            pending_next      = load_data;
            pending_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg      <= '0;
            display_reg      <= '0;
            pending_full_reg <= 1'b0;
        end else begin
            pending_reg      <= pending_next;
            display_reg      <= display_next;
            pending_full_reg <= pending_full_next;
        end
    end

    assign load_ready = ~pending_full_reg;
    assign display    = display_reg;
    // digit 0 of whichever frame becomes visible at the next frame start
    assign next_first = pending_full_reg ? pending_reg[CODE_W-1:0] : display_reg[CODE_W-1:0];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS seven-segment digits through one shared decoder,
// with a blanking guard per slot and tear-free frame updates.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 2,
    parameter int SHOW_CYCLES  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    seg7_scan_ctrl_if.slave       load,
    output logic [CODE_W-1:0]     dec_code,
    input  logic [SEG_W-1:0]      dec_seg,
    output logic [SEG_W-1:0]      seg_out,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_done
);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int MAX_CYC = (BLANK_CYCLES > SHOW_CYCLES) ? BLANK_CYCLES : SHOW_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int FB_W    = CODE_W * NUM_DIGITS;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [IDX_W-1:0]      idx_reg, idx_next, idx_inc;
    logic [CODE_W-1:0]     dec_code_reg, dec_code_next;
    logic [SEG_W-1:0]      seg_reg, seg_next;
    logic [NUM_DIGITS-1:0] dig_reg, dig_next;
    logic                  frame_done_reg, frame_done_next;

    logic                  commit;
    logic [FB_W-1:0]       display_flat;
    logic [CODE_W-1:0]     next_first;
    logic [CODE_W-1:0]     disp_code [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic                  last_digit, blank_end, show_end;

    seg7_frame_buf #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_frame_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load.load_valid),
        .load_data  (load.load_data),
        .load_ready (load.load_ready),
        .commit     (commit),
        .display    (display_flat),
        .next_first (next_first)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign disp_code[gi]  = display_flat[gi*CODE_W +: CODE_W];
            assign sel_onehot[gi] = onehot_bit(int'(idx_reg), gi);
        end
    endgenerate

    assign last_digit = (idx_reg == IDX_W'(NUM_DIGITS - 1));
    assign blank_end  = (cnt_reg == CNT_W'(BLANK_CYCLES - 1));
    assign show_end   = (cnt_reg == CNT_W'(SHOW_CYCLES - 1));
    assign idx_inc    = last_digit ? '0 : idx_reg + 1'b1;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        idx_next        = idx_reg;
        dec_code_next   = dec_code_reg;
        frame_done_next = 1'b0;
        commit          = 1'b0;
        seg_next        = '0;
        dig_next        = '0;

        case (state_reg)
            IDLE: begin
                // pending data is applied straight away while nothing is displayed
                commit   = 1'b1;
                idx_next = '0;
                cnt_next = '0;
                if (enable) begin
                    state_next    = BLANK;
                    dec_code_next = next_first;
                end
            end
            BLANK: begin
                if (blank_end) begin
                    state_next = SHOW;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SHOW: begin
                if (show_end) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    idx_next   = idx_inc;
                    if (last_digit) begin
                        frame_done_next = 1'b1;
                        commit          = 1'b1;
                        dec_code_next   = next_first;
                    end else begin
                        dec_code_next = disp_code[idx_inc];
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
                cnt_next   = '0;
            end
        endcase

        if (!enable) begin
            state_next      = IDLE;
            idx_next        = '0;
            cnt_next        = '0;
            frame_done_next = 1'b0;
            dec_code_next   = dec_code_reg;
            commit          = (state_reg == IDLE);
        end

        // Capture one cycle ahead so the lit window lines up exactly with SHOW.
        if (state_next == SHOW) begin
            seg_next = dec_seg;
            dig_next = sel_onehot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            dec_code_reg   <= '0;
            seg_reg        <= '0;
            dig_reg        <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            dec_code_reg   <= dec_code_next;
            seg_reg        <= seg_next;
            dig_reg        <= dig_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign dec_code   = dec_code_reg;
    assign seg_out    = seg_reg;
    assign dig_en     = dig_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed scenarios then random traffic,
// compared against a frame-position reference model.
module tb_seg7_scan_ctrl;
    import seg7_pkg::*;

    localparam int N     = 4;
    localparam int BL    = 2;
    localparam int SH    = 6;
    localparam int SLOT  = BL + SH;
    localparam int FRAME = N * SLOT;
    localparam int BOUND = 2 * FRAME + 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              enable = 1'b0;
    logic [CODE_W-1:0] dec_code;
    logic [SEG_W-1:0]  dec_seg;
    logic [SEG_W-1:0]  seg_out;
    logic [N-1:0]      dig_en;
    logic              frame_done;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit m_active;
    int m_pos;
    int m_frame [N];
    int m_pend  [N];
    bit m_pend_v;
    bit m_fd;
    int m_acc_cnt;

    seg7_scan_ctrl_if #(.NUM_DIGITS(N)) lif ();

    seg7_scan_ctrl #(
        .NUM_DIGITS   (N),
        .BLANK_CYCLES (BL),
        .SHOW_CYCLES  (SH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (lif),
        .dec_code   (dec_code),
        .dec_seg    (dec_seg),
        .seg_out    (seg_out),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int c);
        case (c)
            0:       return 7'b1111110;
            1:       return 7'b0110000;
            2:       return 7'b1101101;
            3:       return 7'b1111001;
            4:       return 7'b0110011;
            5:       return 7'b1011011;
            6:       return 7'b1011111;
            7:       return 7'b1110000;
            default: return 7'b0000000;
        endcase
    endfunction

    // external shared decoder
    always_comb dec_seg = seg_of(int'(dec_code));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        m_pend_v = 1'b0;
        m_fd     = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_frame[i] = 0;
            m_pend[i]  = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT saw at that edge.
    task automatic model_edge();
        bit acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc  = lif.load_valid && !m_pend_v;
        m_fd = 1'b0;
        if (!enable) begin
            if (!m_active && m_pend_v) begin
                m_frame  = m_pend;
                m_pend_v = 1'b0;
            end
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_pos    = 0;
            if (m_pend_v) begin
                m_frame  = m_pend;
                m_pend_v = 1'b0;
            end
        end else begin
            m_pos++;
            if (m_pos == FRAME) begin
                m_pos = 0;
                m_fd  = 1'b1;
                if (m_pend_v) begin
                    m_frame  = m_pend;
                    m_pend_v = 1'b0;
                end
            end
        end
        if (acc) begin
            for (int i = 0; i < N; i++) m_pend[i] = int'(lif.load_data[3*i +: 3]);
            m_pend_v = 1'b1;
            m_acc_cnt++;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_dig;
        logic [6:0]   e_seg;
        int           slot;
        int           ph;
        e_dig = '0;
        e_seg = '0;
        if (m_active) begin
            slot = m_pos / SLOT;
            ph   = m_pos % SLOT;
            if (ph >= BL) begin
                e_dig[slot] = 1'b1;
                e_seg       = seg_of(m_frame[slot]);
            end
            chk("dec_code", 32'(dec_code), 32'(m_frame[slot]));
        end
        chk("dig_en", 32'(dig_en), 32'(e_dig));
        chk("seg_out", 32'(seg_out), 32'(e_seg));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("load_ready", 32'(lif.load_ready), 32'(!m_pend_v));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_pos(input int slot, input int min_ph, input string tag);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < BOUND; k++) begin
            if (m_active && (m_pos / SLOT == slot) && (m_pos % SLOT >= min_ph)) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        chk(tag, 32'(hit), 32'(1));
    endtask

    task automatic wait_accept(input string tag);
        int start;
        start = m_acc_cnt;
        for (int k = 0; k < BOUND && m_acc_cnt == start; k++) step();
        chk(tag, 32'(m_acc_cnt), 32'(start + 1));
    endtask

    initial begin
        lif.load_valid = 1'b0;
        lif.load_data  = '0;
        m_acc_cnt      = 0;
        model_reset();

        // reset state
        #2 rst_n = 1'b0;
        #2;
        chk("rst_dec_code", 32'(dec_code), 32'(0));
        check_outputs();
        steps(3);
        rst_n  = 1'b1;

        // free-running scan of an all-zero frame
        enable = 1'b1;
        steps(70);

        // load 7531 while idle
        enable = 1'b0;
        steps(2);
        lif.load_valid = 1'b1;
        lif.load_data  = 12'o7531;
        step();
        lif.load_valid = 1'b0;
        steps(2);
        enable = 1'b1;
        steps(40);

        // mid-frame load during digit1
        wait_pos(1, 0, "wait_digit1");
        lif.load_valid = 1'b1;
        lif.load_data  = 12'o2222;
        step();
        lif.load_valid = 1'b0;
        steps(80);

        // second word held while pending is full
        wait_pos(1, 0, "wait_digit1_b");
        lif.load_valid = 1'b1;
        lif.load_data  = 12'o4444;
        wait_accept("accept_first");
        lif.load_data  = 12'o6060;
        wait_accept("accept_second");
        lif.load_valid = 1'b0;
        steps(100);

        // enable drop mid-SHOW of digit2, then restart
        wait_pos(2, BL + 1, "wait_digit2_show");
        enable = 1'b0;
        steps(4);
        enable = 1'b1;
        steps(40);

        // asynchronous reset mid-SHOW
        wait_pos(1, BL + 1, "wait_digit1_show");
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_async_dec_code", 32'(dec_code), 32'(0));
        steps(2);
        rst_n = 1'b1;
        steps(40);

        // random traffic
        for (int k = 0; k < 2500; k++) begin
            enable         = ($urandom_range(0, 99) < 97);
            lif.load_valid = ($urandom_range(0, 9) == 0);
            lif.load_data  = 12'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
